// File: rtl/wb_mem_pkg.sv
// Shared types and helpers for the delayed Wishbone BRAM slave.
// Holds the FSM encoding, bus widths and the window decode.
package wb_mem_pkg;

   localparam int WB_DW   = 32;
   localparam int WB_SELW = 4;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      ACCESS,
      ACK
   } state_t;

   function automatic logic in_window(
      input logic [31:0] adr,
      input logic [31:0] base
   );
      return adr[31:24] == base[31:24];
   endfunction

endpackage

// File: rtl/bram_sp32.sv
// Single-port 32-bit RAM, byte write enables, registered read.
// Kept standalone so a hardened SRAM macro can replace it.
module bram_sp32 #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [3:0]        sel,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata
);

   logic [31:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int b = 0; b < 4; b++) begin
               if (sel[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/wb_delayed_bram.sv
// Wishbone classic slave over a BRAM with programmable wait states.
// One access outstanding; abort allowed only while waiting.
module wb_delayed_bram #(
   parameter int          DELAYS   = 10,
   parameter logic [31:0] BASE_ADR = 32'h3800_0000,
   parameter int          ADDR_W   = 10
) (
   input  logic        wb_clk_i,
   input  logic        resetb,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic        busy_o
);

   import wb_mem_pkg::*;

   localparam logic [7:0] DLY = 8'(DELAYS);

   state_t              state_q, state_d;
   logic [7:0]          cnt_q, cnt_d;
   logic                latch;
   logic                req;
   logic [ADDR_W-1:0]   adr_q;
   logic                we_q;
   logic [WB_SELW-1:0]  sel_q;
   logic [WB_DW-1:0]    dat_q;
   logic [WB_DW-1:0]    rd;
   logic                unused_adr;

   assign unused_adr = ^{wbs_adr_i[23:ADDR_W+2],
                         wbs_adr_i[1:0]};

   assign req = wbs_cyc_i & wbs_stb_i &
                in_window(wbs_adr_i, BASE_ADR);

   always_ff @(posedge wb_clk_i or negedge resetb) begin
      if (!resetb) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge wb_clk_i or negedge resetb) begin
      if (!resetb) begin
         adr_q <= '0;
         we_q  <= 1'b0;
         sel_q <= '0;
         dat_q <= '0;
      end else if (latch) begin
         adr_q <= wbs_adr_i[ADDR_W+1:2];
         we_q  <= wbs_we_i;
         sel_q <= wbs_sel_i;
         dat_q <= wbs_dat_i;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      latch   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req) begin
               state_d = WAIT;
               cnt_d   = DLY;
               latch   = 1'b1;
            end
         end
         WAIT: begin
            if (!wbs_cyc_i) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == 8'd0) begin
               state_d = ACCESS;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ACCESS:  state_d = ACK;
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   bram_sp32 #(.ADDR_W(ADDR_W)) u_bram (
      .clk   (wb_clk_i),
      .en    (state_q == ACCESS),
      .we    (we_q),
      .sel   (sel_q),
      .addr  (adr_q),
      .wdata (dat_q),
      .rdata (rd)
   );

   // Read word is gated so dat is zero outside a read ack.
   assign wbs_ack_o = (state_q == ACK);
   assign wbs_dat_o = (state_q == ACK && !we_q) ? rd : '0;
   assign busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_wb_delayed_bram.sv
// Bench for wb_delayed_bram: DELAYS=10 and DELAYS=0 instances.
// Scoreboard queue holds the expected ack data per transfer.
module tb_wb_delayed_bram;

   logic        clk = 1'b0;
   logic        resetb;
   logic        cyc  [2];
   logic        stb  [2];
   logic        we   [2];
   logic [3:0]  sel  [2];
   logic [31:0] adr  [2];
   logic [31:0] wdat [2];
   logic        ack  [2];
   logic [31:0] rdat [2];
   logic        busy [2];

   logic [31:0] model [int];
   logic [31:0] sb_q [$];
   int n_run  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   wb_delayed_bram #(.DELAYS(10)) dut0 (
      .wb_clk_i  (clk),
      .resetb    (resetb),
      .wbs_cyc_i (cyc[0]),
      .wbs_stb_i (stb[0]),
      .wbs_we_i  (we[0]),
      .wbs_sel_i (sel[0]),
      .wbs_adr_i (adr[0]),
      .wbs_dat_i (wdat[0]),
      .wbs_ack_o (ack[0]),
      .wbs_dat_o (rdat[0]),
      .busy_o    (busy[0])
   );

   wb_delayed_bram #(.DELAYS(0)) dut1 (
      .wb_clk_i  (clk),
      .resetb    (resetb),
      .wbs_cyc_i (cyc[1]),
      .wbs_stb_i (stb[1]),
      .wbs_we_i  (we[1]),
      .wbs_sel_i (sel[1]),
      .wbs_adr_i (adr[1]),
      .wbs_dat_i (wdat[1]),
      .wbs_ack_o (ack[1]),
      .wbs_dat_o (rdat[1]),
      .busy_o    (busy[1])
   );

   task automatic xfer(
      input int          d,
      input logic        w,
      input logic [31:0] a,
      input logic [31:0] dt,
      input logic [3:0]  s,
      input int          lat,
      input string       nm
   );
      logic [31:0] exp_d, got_d, cur;
      int key, edges;
      logic got, busy_ok;
      key = d * 4096 + int'(a[11:2]);
      if (w) begin
         cur = model.exists(key) ? model[key] : 32'h0;
         for (int b = 0; b < 4; b++)
            if (s[b]) cur[8*b +: 8] = dt[8*b +: 8];
         model[key] = cur;
         exp_d = 32'h0;
      end else begin
         exp_d = model[key];
      end
      sb_q.push_back(exp_d);
      cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w;
      adr[d] = a; wdat[d] = dt; sel[d] = s;
      edges = 0; got = 1'b0; busy_ok = 1'b1;
      while (!got && edges < 400) begin
         @(posedge clk); #1;
         edges++;
         if (ack[d]) got = 1'b1;
         else if (busy[d] !== 1'b1) busy_ok = 1'b0;
      end
      cyc[d] = 1'b0; stb[d] = 1'b0;
      n_run++;
      if (!got) begin
         n_fail++;
         $display("FAIL %s ack: none after %0d edges", nm, edges);
         void'(sb_q.pop_front());
      end else begin
         got_d = rdat[d];
         exp_d = sb_q.pop_front();
         n_run++;
         if (got_d !== exp_d) begin
            n_fail++;
            $display("FAIL %s dat: got %h exp %h", nm, got_d, exp_d);
         end
         n_run++;
         if (edges - 1 != lat) begin
            n_fail++;
            $display("FAIL %s lat: got %0d exp %0d", nm, edges - 1, lat);
         end
         n_run++;
         if (!busy_ok) begin
            n_fail++;
            $display("FAIL %s busy: got 0 exp 1 during access", nm);
         end
      end
      @(posedge clk); #1;
      n_run++;
      if ({ack[d], busy[d], rdat[d]} !== 34'h0) begin
         n_fail++;
         $display("FAIL %s post: ack %b busy %b dat %h exp 0",
                  nm, ack[d], busy[d], rdat[d]);
      end
   endtask

   task automatic test_reset();
      resetb = 1'b0;
      for (int d = 0; d < 2; d++) begin
         cyc[d] = 0; stb[d] = 0; we[d] = 0;
         sel[d] = 0; adr[d] = 0; wdat[d] = 0;
      end
      #1;
      for (int d = 0; d < 2; d++) begin
         n_run++;
         if ({ack[d], busy[d], rdat[d]} !== 34'h0) begin
            n_fail++;
            $display("FAIL reset%0d: ack %b busy %b dat %h exp 0",
                     d, ack[d], busy[d], rdat[d]);
         end
      end
      repeat (3) @(posedge clk);
      #1 resetb = 1'b1;
   endtask

   task automatic test_read();
      xfer(0, 1, 32'h3800_0000, 32'hDEAD_BEEF, 4'hF, 12, "pre0");
      xfer(0, 0, 32'h3800_0000, 32'h0, 4'hF, 12, "rd0");
   endtask

   task automatic test_byte_mask();
      xfer(0, 1, 32'h3800_0010, 32'hAAAA_AAAA, 4'hF, 12, "preA");
      xfer(0, 1, 32'h3800_0010, 32'h1122_3344, 4'b0101, 12, "wsel");
      xfer(0, 0, 32'h3800_0010, 32'h0, 4'hF, 12, "rsel");
      n_run++;
      if (model[4] !== 32'hAA22_AA44) begin
         n_fail++;
         $display("FAIL selmodel: got %h exp aa22aa44", model[4]);
      end
   endtask

   task automatic test_abort();
      logic bad;
      xfer(0, 1, 32'h3800_0020, 32'h5566_7788, 4'hF, 12, "preB");
      cyc[0] = 1; stb[0] = 1; we[0] = 1;
      adr[0] = 32'h3800_0020; wdat[0] = 32'hFFFF_FFFF; sel[0] = 4'hF;
      bad = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
         if (ack[0] !== 1'b0 || busy[0] !== 1'b1) bad = 1'b1;
      end
      n_run++;
      if (bad) begin
         n_fail++;
         $display("FAIL abort_wait: got ack/idle exp busy no ack");
      end
      cyc[0] = 0; stb[0] = 0;
      @(posedge clk); #1;
      n_run++;
      if (busy[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_busy: got %b exp 0", busy[0]);
      end
      bad = 1'b0;
      repeat (20) begin
         @(posedge clk); #1;
         if (ack[0] !== 1'b0) bad = 1'b1;
      end
      n_run++;
      if (bad) begin
         n_fail++;
         $display("FAIL abort_ack: got 1 exp 0");
      end
      xfer(0, 0, 32'h3800_0020, 32'h0, 4'hF, 12, "rdB");
   endtask

   task automatic test_out_of_window();
      logic bad;
      cyc[0] = 1; stb[0] = 1; we[0] = 0;
      adr[0] = 32'h3000_0000; sel[0] = 4'hF;
      bad = 1'b0;
      repeat (30) begin
         @(posedge clk); #1;
         if (ack[0] !== 1'b0 || busy[0] !== 1'b0) bad = 1'b1;
      end
      cyc[0] = 0; stb[0] = 0;
      n_run++;
      if (bad) begin
         n_fail++;
         $display("FAIL oow: got ack/busy exp 0");
      end
   endtask

   task automatic test_alias();
      xfer(0, 1, 32'h3800_1004, 32'hCAFE_0123, 4'hF, 12, "alw0");
      xfer(0, 0, 32'h3800_0004, 32'h0, 4'hF, 12, "alr0");
      xfer(1, 1, 32'h3800_1004, 32'h0BAD_CAFE, 4'hF, 2, "alw1");
      xfer(1, 0, 32'h3800_0004, 32'h0, 4'hF, 2, "alr1");
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         xfer(1, 1, 32'h3800_0100 + 32'(4 * i),
              32'($urandom), 4'hF, 2, "b2bw");
      end
      for (int i = 0; i < 4; i++) begin
         xfer(1, 0, 32'h3800_0100 + 32'(4 * i),
              32'h0, 4'hF, 2, "b2br");
      end
   endtask

   task automatic test_reset_mid();
      xfer(0, 1, 32'h3800_0030, 32'h0BAD_F00D, 4'hF, 12, "preC");
      cyc[0] = 1; stb[0] = 1; we[0] = 1;
      adr[0] = 32'h3800_0030; wdat[0] = 32'h1234_5678; sel[0] = 4'hF;
      repeat (4) @(posedge clk);
      #1 resetb = 1'b0;
      #1;
      n_run++;
      if ({ack[0], busy[0], rdat[0]} !== 34'h0) begin
         n_fail++;
         $display("FAIL rstmid: ack %b busy %b dat %h exp 0",
                  ack[0], busy[0], rdat[0]);
      end
      cyc[0] = 0; stb[0] = 0;
      @(posedge clk); #1 resetb = 1'b1;
      @(posedge clk); #1;
      xfer(0, 0, 32'h3800_0030, 32'h0, 4'hF, 12, "rdC");
   endtask

   initial begin
      test_reset();
      test_read();
      test_byte_mask();
      test_abort();
      test_out_of_window();
      test_alias();
      test_back_to_back();
      test_reset_mid();
      n_run++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL sb_left: got %0d exp 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
